// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and the round-robin pick helper for div_arbiter.
// Contents:
//   div_arb_state_t - arbiter FSM state (IDLE, ISSUE, WAIT)
//   rr_pick_t       - result of rr_pick (found flag + grant index)
//   rr_pick()       - first set bit of valid searching upward from ptr+1, wrapping
package div_arb_pkg;

   localparam int unsigned RR_MAX  = 8;
   localparam int unsigned RR_IDXW = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } div_arb_state_t;

   typedef struct packed {
      logic               found;
      logic [RR_IDXW-1:0] idx;
   } rr_pick_t;

   // Operates on an 8-wide vector; unused upper bits are zero, so wrapping
   // modulo 8 gives the same order as wrapping modulo the real requester count.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]  valid,
                                        input logic [RR_IDXW-1:0] ptr);
      rr_pick_t           res;
      logic [RR_IDXW-1:0] cand;
      res = '0;
      // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1)
      // so the nearest valid requester is the one left in res.
      for (int k = RR_MAX; k >= 1; k--) begin
         cand = ptr + RR_IDXW'(k);
         if (valid[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports:
//   req_i    - request vector
//   ptr_i    - index of the last grant; search starts at ptr_i+1
//   gnt_c_o  - one-hot grant
//   idx_c_o  - grant index
//   any_c_o  - any request granted
module rr_arbiter
   import div_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDXW    = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDXW-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_c_o,
   output logic [IDXW-1:0]    idx_c_o,
   output logic               any_c_o
);

   rr_pick_t pick;

   always_comb begin
      pick    = rr_pick(RR_MAX'(req_i), RR_IDXW'(ptr_i));
      any_c_o = pick.found;
      idx_c_o = IDXW'(pick.idx);
      gnt_c_o = '0;
      if (pick.found) gnt_c_o[idx_c_o] = 1'b1;
   end

endmodule

// File: rtl/divider.sv
// divider: sequential restoring unsigned divider, one quotient bit per cycle.
// Latency: result strobe WIDTH+1 cycles after the launch cycle.
// Divisor 0 yields quotient all-ones, remainder = dividend, error_out = 1.
// Ports:
//   clk_in, rst_in (async, active-high)
//   data_valid_in            - launch (ignored while busy)
//   dividend_in, divisor_in  - operands, sampled on launch
//   data_valid_out           - one-cycle result strobe
//   quotient_out, remainder_out, error_out - result (valid with the strobe)
module divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             data_valid_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             data_valid_out,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic             error_out
);

   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // One restoring step: shift the next dividend bit into the partial remainder.
   assign trial = {rem_q, quo_q[WIDTH-1]};
   assign ge    = trial >= {1'b0, dvs_q};
   assign diff  = trial[WIDTH-1:0] - dvs_q;

   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      err_d  = err_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      if (!busy_q && data_valid_in) begin
         busy_d = 1'b1;
         cnt_d  = CNTW'(WIDTH);
         rem_d  = '0;
         quo_d  = dividend_in;
         dvs_d  = divisor_in;
         err_d  = (divisor_in == '0);
      end else if (busy_q) begin
         rem_d = ge ? diff : trial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], ge};
         cnt_d = cnt_q - CNTW'(1);
         if (cnt_q == CNTW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
      end
   end

   assign data_valid_out = done_q;
   assign quotient_out   = quo_q;
   assign remainder_out  = rem_q;
   assign error_out      = err_q;

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one sequential divider between NUM_REQ requesters with
// round-robin grants; one operation outstanding at a time.
// Optional: define DIV_ARB_ZERO_BYPASS_EN to answer divisor-0 requests directly
// from IDLE without launching the divider.
// Ports:
//   clk_in, rst_in (async, active-high)
//   req_valid_in / req_ready_out  - per-requester request handshake (ready one-hot)
//   dividend_in, divisor_in       - packed operands, requester i at [i*WIDTH +: WIDTH]
//   quotient_out, remainder_out, error_out - last result, held until the next one
//   resp_valid_out                - one-hot one-cycle response strobe
//   resp_id_out                   - owner of the current result
//   busy_out                      - FSM not in IDLE
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [NUM_REQ-1:0]       req_valid_in,
   output logic [NUM_REQ-1:0]       req_ready_out,
   input  logic [NUM_REQ*WIDTH-1:0] dividend_in,
   input  logic [NUM_REQ*WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0]         quotient_out,
   output logic [WIDTH-1:0]         remainder_out,
   output logic                     error_out,
   output logic [NUM_REQ-1:0]       resp_valid_out,
   output logic [IDXW-1:0]          resp_id_out,
   output logic                     busy_out
);

   div_arb_state_t     state_q, state_d;
   logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, resp_id_q, resp_id_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
   logic               err_q, err_d;
   logic [NUM_REQ-1:0] resp_v_q, resp_v_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IDXW-1:0]    gnt_idx;
   logic               any_gnt;
   logic [31:0]        sel_base;
   logic [WIDTH-1:0]   sel_dvd, sel_dvs;
   logic               div_start, div_done, div_err;
   logic [WIDTH-1:0]   div_quo, div_rem;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
      .req_i   (req_valid_in),
      .ptr_i   (rr_ptr_q),
      .gnt_c_o (gnt),
      .idx_c_o (gnt_idx),
      .any_c_o (any_gnt)
   );

   // Operands of the currently granted requester.
   assign sel_base = 32'(gnt_idx) * 32'(WIDTH);
   assign sel_dvd  = dividend_in[sel_base +: WIDTH];
   assign sel_dvs  = divisor_in[sel_base +: WIDTH];

   divider #(.WIDTH(WIDTH)) u_div (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .data_valid_in  (div_start),
      .dividend_in    (dvd_q),
      .divisor_in     (dvs_q),
      .data_valid_out (div_done),
      .quotient_out   (div_quo),
      .remainder_out  (div_rem),
      .error_out      (div_err)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      err_d     = err_q;
      resp_id_d = resp_id_q;
      resp_v_d  = '0;
      div_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_gnt) begin
               rr_ptr_d = gnt_idx;
               id_d     = gnt_idx;
               dvd_d    = sel_dvd;
               dvs_d    = sel_dvs;
`ifdef DIV_ARB_ZERO_BYPASS_EN
               if (sel_dvs == '0) begin
                  quo_d     = '1;
                  rem_d     = sel_dvd;
                  err_d     = 1'b1;
                  resp_id_d = gnt_idx;
                  resp_v_d  = gnt;
               end else begin
                  state_d = ISSUE;
               end
`else
               state_d = ISSUE;
`endif
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (div_done) begin
               quo_d        = div_quo;
               rem_d        = div_rem;
               err_d        = div_err;
               resp_id_d    = id_q;
               resp_v_d     = '0;
               resp_v_d[id_q] = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         rr_ptr_q  <= IDXW'(NUM_REQ - 1);
         id_q      <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         err_q     <= 1'b0;
         resp_id_q <= '0;
         resp_v_q  <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         err_q     <= err_d;
         resp_id_q <= resp_id_d;
         resp_v_q  <= resp_v_d;
      end
   end

   assign req_ready_out  = (state_q == IDLE && any_gnt) ? gnt : '0;
   assign quotient_out   = quo_q;
   assign remainder_out  = rem_q;
   assign error_out      = err_q;
   assign resp_valid_out = resp_v_q;
   assign resp_id_out    = resp_id_q;
   assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for div_arbiter (NUM_REQ=2, WIDTH=32).
module tb_div_arbiter;

   localparam int unsigned NR = 2;
   localparam int unsigned W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*W-1:0]   dvd, dvs;
   logic [W-1:0]      quo, rem;
   logic              err;
   logic [NR-1:0]     resp_v;
   logic              resp_id;
   logic              busy;

   int n_checks = 0;
   int n_pass   = 0;
   int busy_viol = 0;

   always #5 clk = ~clk;

   div_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .req_valid_in   (req_valid),
      .req_ready_out  (req_ready),
      .dividend_in    (dvd),
      .divisor_in     (dvs),
      .quotient_out   (quo),
      .remainder_out  (rem),
      .error_out      (err),
      .resp_valid_out (resp_v),
      .resp_id_out    (resp_id),
      .busy_out       (busy)
   );

   // Ready must never be offered while an operation is in progress.
   always @(negedge clk) if (!rst && busy && req_ready != '0) busy_viol++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
      dvd[r*W +: W] = a;
      dvs[r*W +: W] = b;
   endtask

   // Raise one request, wait (bounded) for ready, check it, drop valid after the accept edge.
   task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [NR-1:0] exp_g;
      exp_g    = '0;
      exp_g[r] = 1'b1;
      @(posedge clk); #1;
      set_op(r, a, b);
      req_valid[r] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready != '0) break;
         @(posedge clk); #1;
      end
      check_eq(tag, 64'(req_ready), 64'(exp_g));
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_resp(input string tag, output logic [NR-1:0] rv);
      rv = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (resp_v != '0) begin
            rv = resp_v;
            break;
         end
      end
      check_eq({tag, "_seen"}, 64'(rv != '0), 64'd1);
   endtask

   logic [NR-1:0] rv;
   logic [NR-1:0] order [4];
   logic [W-1:0]  expq  [4];
   logic [NR-1:0] drop, raise;
   int g, k, stray;

   initial begin
      rst = 1'b1; req_valid = '0; dvd = '0; dvs = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", 64'(req_ready), 64'd0);
      check_eq("rst_quo",   64'(quo), 64'd0);
      check_eq("rst_rem",   64'(rem), 64'd0);
      check_eq("rst_err",   64'(err), 64'd0);
      check_eq("rst_resp",  64'(resp_v), 64'd0);
      check_eq("rst_id",    64'(resp_id), 64'd0);
      check_eq("rst_busy",  64'(busy), 64'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Single request 100/7.
      issue(0, 32'd100, 32'd7, "t1_grant");
      @(negedge clk);
      check_eq("t1_busy", 64'(busy), 64'd1);
      wait_resp("t1", rv);
      check_eq("t1_resp", 64'(rv), 64'h1);
      check_eq("t1_quo",  64'(quo), 64'd14);
      check_eq("t1_rem",  64'(rem), 64'd2);
      check_eq("t1_err",  64'(err), 64'd0);
      check_eq("t1_id",   64'(resp_id), 64'd0);
      @(negedge clk);
      check_eq("t1_strobe_1cyc", 64'(resp_v), 64'd0);
      check_eq("t1_idle", 64'(busy), 64'd0);
      check_eq("t1_hold", 64'(quo), 64'd14);

      // Contention from reset: both held valid, re-requested after own response.
      @(posedge clk); #1;
      rst = 1'b1;
      set_op(0, 32'd50, 32'd5);
      set_op(1, 32'd81, 32'd9);
      req_valid = 2'b11;
      @(posedge clk); #1; rst = 1'b0;
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
      expq[0] = 32'd10; expq[1] = 32'd9; expq[2] = 32'd10; expq[3] = 32'd9;
      g = 0; k = 0;
      for (int cyc = 0; cyc < 600 && k < 4; cyc++) begin
         drop = '0; raise = '0;
         @(negedge clk);
         if (req_ready != '0) begin
            if (g < 4) check_eq($sformatf("t2_grant%0d", g), 64'(req_ready), 64'(order[g]));
            drop = req_ready;
            g++;
         end
         if (resp_v != '0) begin
            check_eq($sformatf("t2_resp%0d", k), 64'(resp_v), 64'(order[k]));
            check_eq($sformatf("t2_quo%0d", k), 64'(quo), 64'(expq[k]));
            if (k < 3) check_eq($sformatf("t2_b2b%0d", k), 64'(req_ready), 64'(order[k+1]));
            if (g < 4) raise = resp_v;
            k++;
         end
         @(posedge clk); #1;
         req_valid = (req_valid & ~drop) | raise;
      end
      check_eq("t2_nresp",  64'(k), 64'd4);
      check_eq("t2_ngrant", 64'(g), 64'd4);
      req_valid = '0;

      // Divide by zero on requester 1.
      issue(1, 32'd42, 32'd0, "t3_grant");
`ifdef DIV_ARB_ZERO_BYPASS_EN
      @(negedge clk);
      rv = resp_v;
      check_eq("t3_bypass_idle", 64'(busy), 64'd0);
`else
      wait_resp("t3", rv);
`endif
      check_eq("t3_resp", 64'(rv), 64'h2);
      check_eq("t3_err",  64'(err), 64'd1);
      check_eq("t3_quo",  64'(quo), 64'hFFFF_FFFF);
      check_eq("t3_rem",  64'(rem), 64'd42);
      check_eq("t3_id",   64'(resp_id), 64'd1);

      // Reset while waiting on the divider.
      issue(1, 32'd1000, 32'd3, "t4_grant");
      repeat (10) @(negedge clk);
      check_eq("t4_in_wait", 64'(busy), 64'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_eq("t4_async_busy", 64'(busy), 64'd0);
      check_eq("t4_async_quo",  64'(quo), 64'd0);
      check_eq("t4_async_rem",  64'(rem), 64'd0);
      check_eq("t4_async_err",  64'(err), 64'd0);
      check_eq("t4_async_id",   64'(resp_id), 64'd0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (resp_v != '0) stray++;
      end
      check_eq("t4_no_resp", 64'(stray), 64'd0);
      @(posedge clk); #1;
      set_op(0, 32'd9, 32'd3);
      set_op(1, 32'd5, 32'd5);
      req_valid = 2'b11;
      @(negedge clk);
      check_eq("t4_first_r0", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp("t4", rv);
      check_eq("t4_resp", 64'(rv), 64'h1);
      check_eq("t4_quo",  64'(quo), 64'd3);

      // Requester 1 withdraws while the arbiter is busy.
      issue(0, 32'd20, 32'd6, "t5_grant");
      repeat (3) @(posedge clk); #1;
      set_op(1, 32'd5, 32'd5);
      req_valid[1] = 1'b1;
      repeat (7) @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_resp("t5", rv);
      check_eq("t5_resp", 64'(rv), 64'h1);
      check_eq("t5_quo",  64'(quo), 64'd3);
      check_eq("t5_rem",  64'(rem), 64'd2);
      stray = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (resp_v != '0 || req_ready != '0) stray++;
      end
      check_eq("t5_no_r1", 64'(stray), 64'd0);
      issue(0, 32'd77, 32'd7, "t5_next_grant");
      wait_resp("t5_next", rv);
      check_eq("t5_next_resp", 64'(rv), 64'h1);
      check_eq("t5_next_quo",  64'(quo), 64'd11);
      check_eq("t5_next_rem",  64'(rem), 64'd0);

      check_eq("ready_while_busy", 64'(busy_viol), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
